risc_boot_ctrl: RTL and testbench

Boot and memory-port controller for the `risc` core in the TinyTapeout top level. It takes the pin-level program-load interface, synchronises it, and turns each write strobe into a single-cycle instruction-memory write. It holds the core in reset while loading and releases it through a settle window. It arbitrates the single instruction-memory port between loader writes and CPU fetches.

---
 rtl/risc_boot_ctrl.sv | 119 +++++++++++
 tb/tb_risc_boot_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/risc_boot_ctrl.sv
// risc_boot_ctrl: boot and instruction-memory port controller for the risc core.
// Synchronises the pin-level program loader and turns each ld_we strobe into a
// single-cycle memory write. Holds the core in reset while loading, and releases
// it through a settle window. Arbitrates the single memory port between loader
// writes and CPU fetches.
module risc_boot_ctrl #(
  parameter int ADDR_W        = 7,
  parameter int DATA_W        = 8,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              run_en,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_gnt,
  output logic              cpu_rst_n,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [1:0]        state,
  output logic [7:0]        wr_count
);

  typedef enum logic [1:0] {
    LOAD   = 2'b00,
    SETTLE = 2'b01,
    RUN    = 2'b10
  } state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t            st;
  logic              we_s1, we_s2, we_s3;
  logic              run_s1, run_s2;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        settle_cnt;
  logic              wr_pulse;

  // Rising edge of the synchronised write strobe.
  assign wr_pulse = we_s2 & ~we_s3;
  assign state    = st;

  // Two-flop synchronisers for the pin inputs, plus the ld_we edge flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_s1  <= 1'b0;
      we_s2  <= 1'b0;
      we_s3  <= 1'b0;
      run_s1 <= 1'b0;
      run_s2 <= 1'b0;
    end else begin
      we_s1  <= ld_we;
      we_s2  <= we_s1;
      we_s3  <= we_s2;
      run_s1 <= run_en;
      run_s2 <= run_s1;
    end
  end

  // Write capture, write counter and the boot FSM with registered core reset.
  // cpu_rst_n is assigned alongside each next-state choice so it tracks RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st         <= LOAD;
      cpu_rst_n  <= 1'b0;
      mem_we     <= 1'b0;
      mem_wdata  <= '0;
      addr_q     <= '0;
      wr_count   <= '0;
      settle_cnt <= '0;
    end else begin
      mem_we    <= wr_pulse;
      cpu_rst_n <= 1'b0;
      if (wr_pulse) begin
        addr_q    <= ld_addr;
        mem_wdata <= ld_data;
        if (wr_count != 8'hFF) wr_count <= wr_count + 8'd1;
      end
      case (st)
        LOAD: begin
          if (run_s2 && !wr_pulse) begin
            st         <= SETTLE;
            settle_cnt <= SETTLE_LOAD;
          end
        end
        SETTLE: begin
          if (wr_pulse || !run_s2) begin
            st <= LOAD;
          end else if (settle_cnt == 4'd0) begin
            st        <= RUN;
            cpu_rst_n <= 1'b1;
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end
        RUN: begin
          if (wr_pulse || !run_s2) st <= LOAD;
          else                     cpu_rst_n <= 1'b1;
        end
        default: st <= LOAD;
      endcase
    end
  end

  // Memory port arbitration: a loader write always wins over a CPU fetch.
  always_comb begin
    mem_addr = addr_q;
    cpu_gnt  = 1'b0;
    if (!mem_we && st == RUN) begin
      mem_addr = cpu_addr;
      cpu_gnt  = cpu_req;
    end
  end

endmodule

// File: tb/tb_risc_boot_ctrl.sv
// Testbench for risc_boot_ctrl: scenario tasks with a write scoreboard.
module tb_risc_boot_ctrl;

  localparam int AW = 7;
  localparam int DW = 8;
  localparam int SC = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ld_we;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  logic          run_en;
  logic          cpu_req;
  logic [AW-1:0] cpu_addr;
  logic          cpu_gnt;
  logic          cpu_rst_n;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [1:0]    state;
  logic [7:0]    wr_count;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t sb[$];
  int  vec = 0;
  int  errs = 0;
  int  exp_cnt = 0;
  int  pulses = 0;

  risc_boot_ctrl #(.ADDR_W(AW), .DATA_W(DW), .SETTLE_CYCLES(SC)) dut (
    .clk(clk), .rst_n(rst_n), .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
    .run_en(run_en), .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_gnt(cpu_gnt),
    .cpu_rst_n(cpu_rst_n), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .state(state), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (mem_we === 1'b1) pulses++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one strobe; returns just after the edge where mem_we should rise,
  // with ld_we still high.
  task automatic do_strobe(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit with_run);
    wr_t e;
    ld_addr = a;
    ld_data = d;
    sb.push_back({a, d});
    exp_cnt = (exp_cnt >= 255) ? 255 : exp_cnt + 1;
    tick();
    ld_we = 1'b1;
    if (with_run) run_en = 1'b1;
    tick();  // edge k: first sample
    tick();  // k+1
    vec++; if (mem_we !== 1'b0) begin errs++; $display("FAIL early_we mem_we=%b want 0", mem_we); end
    tick();  // k+2
    vec++; if (mem_we !== 1'b1) begin errs++; $display("FAIL wr_pulse mem_we=%b want 1", mem_we); end
    if (sb.size() == 0) begin
      vec++; errs++; $display("FAIL sb_empty no expected write queued");
    end else begin
      e = sb.pop_front();
      vec++; if (mem_addr !== e.a) begin errs++; $display("FAIL wr_addr got %h want %h", mem_addr, e.a); end
      vec++; if (mem_wdata !== e.d) begin errs++; $display("FAIL wr_data got %h want %h", mem_wdata, e.d); end
    end
    vec++; if (cpu_gnt !== 1'b0) begin errs++; $display("FAIL wr_gnt got %b want 0", cpu_gnt); end
    vec++; if (wr_count !== 8'(exp_cnt)) begin errs++; $display("FAIL wr_count got %0d want %0d", wr_count, exp_cnt); end
  endtask

  task automatic finish_strobe();
    tick();  // k+3
    vec++; if (mem_we !== 1'b0) begin errs++; $display("FAIL one_cycle mem_we=%b want 0", mem_we); end
    ld_we = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_data = '0;
    run_en = 1'b0; cpu_req = 1'b0; cpu_addr = '0;
    tick(); tick();
    vec++; if (state !== 2'b00) begin errs++; $display("FAIL rst_state got %b want 00", state); end
    vec++; if (cpu_rst_n !== 1'b0) begin errs++; $display("FAIL rst_cpu_rst_n got %b want 0", cpu_rst_n); end
    vec++; if (mem_we !== 1'b0) begin errs++; $display("FAIL rst_mem_we got %b want 0", mem_we); end
    vec++; if (mem_wdata !== '0) begin errs++; $display("FAIL rst_wdata got %h want 0", mem_wdata); end
    vec++; if (wr_count !== 8'd0) begin errs++; $display("FAIL rst_count got %0d want 0", wr_count); end
    vec++; if (cpu_gnt !== 1'b0) begin errs++; $display("FAIL rst_gnt got %b want 0", cpu_gnt); end
    rst_n = 1'b1;
    exp_cnt = 0;
    tick();
  endtask

  task automatic test_single_write();
    do_strobe(7'h05, 8'hA3, 1'b0);
    vec++; if (cpu_rst_n !== 1'b0) begin errs++; $display("FAIL load_cpu_rst_n got %b want 0", cpu_rst_n); end
    finish_strobe();
  endtask

  task automatic test_start();
    do_strobe(7'h01, 8'h11, 1'b0); finish_strobe();
    do_strobe(7'h02, 8'h22, 1'b0); finish_strobe();
    run_en = 1'b1;
    tick();  // k
    tick();  // k+1
    vec++; if (state !== 2'b00) begin errs++; $display("FAIL start_k1 state %b want 00", state); end
    tick();  // k+2
    vec++; if (state !== 2'b01) begin errs++; $display("FAIL start_k2 state %b want 01", state); end
    for (int i = 3; i <= 5; i++) begin
      tick();
      vec++; if (state !== 2'b01 || cpu_rst_n !== 1'b0) begin
        errs++; $display("FAIL settle_hold k+%0d state %b rst %b want 01/0", i, state, cpu_rst_n);
      end
    end
    tick();  // k+6
    vec++; if (state !== 2'b10) begin errs++; $display("FAIL start_run state %b want 10", state); end
    vec++; if (cpu_rst_n !== 1'b1) begin errs++; $display("FAIL start_cpu_rst_n got %b want 1", cpu_rst_n); end
    cpu_req = 1'b1; cpu_addr = 7'h02;
    #1;
    vec++; if (cpu_gnt !== 1'b1) begin errs++; $display("FAIL fetch_gnt got %b want 1", cpu_gnt); end
    vec++; if (mem_addr !== 7'h02) begin errs++; $display("FAIL fetch_addr got %h want 02", mem_addr); end
  endtask

  task automatic test_write_in_run();
    cpu_addr = 7'h10;
    tick();
    vec++; if (cpu_gnt !== 1'b1 || mem_addr !== 7'h10) begin
      errs++; $display("FAIL run_fetch gnt %b addr %h want 1/10", cpu_gnt, mem_addr);
    end
    do_strobe(7'h10, 8'h7E, 1'b0);  // k+2 checks gnt=0, addr=10
    vec++; if (state !== 2'b00) begin errs++; $display("FAIL hot_state got %b want 00", state); end
    vec++; if (cpu_rst_n !== 1'b0) begin errs++; $display("FAIL hot_cpu_rst_n got %b want 0", cpu_rst_n); end
    tick();  // k+3
    vec++; if (state !== 2'b01 || mem_we !== 1'b0) begin
      errs++; $display("FAIL hot_settle state %b we %b want 01/0", state, mem_we);
    end
    ld_we = 1'b0;
    for (int i = 4; i <= 6; i++) begin
      tick();
      vec++; if (state !== 2'b01 || cpu_rst_n !== 1'b0) begin
        errs++; $display("FAIL hot_hold k+%0d state %b rst %b want 01/0", i, state, cpu_rst_n);
      end
    end
    tick();  // k+7
    vec++; if (state !== 2'b10 || cpu_rst_n !== 1'b1) begin
      errs++; $display("FAIL hot_run state %b rst %b want 10/1", state, cpu_rst_n);
    end
    vec++; if (cpu_gnt !== 1'b1 || mem_addr !== 7'h10) begin
      errs++; $display("FAIL hot_fetch gnt %b addr %h want 1/10", cpu_gnt, mem_addr);
    end
    cpu_req = 1'b0;
  endtask

  task automatic test_settle_abort();
    run_en = 1'b0;
    tick(); tick();  // j, j+1
    vec++; if (state !== 2'b10) begin errs++; $display("FAIL stop_j1 state %b want 10", state); end
    tick();  // j+2
    vec++; if (state !== 2'b00 || cpu_rst_n !== 1'b0) begin
      errs++; $display("FAIL stop state %b rst %b want 00/0", state, cpu_rst_n);
    end
    run_en = 1'b1;
    tick(); tick(); tick();  // k..k+2
    vec++; if (state !== 2'b01) begin errs++; $display("FAIL abort_settle state %b want 01", state); end
    tick();  // k+3, counter now 2
    run_en = 1'b0;
    for (int i = 4; i <= 8; i++) begin
      tick();
      vec++; if (cpu_rst_n !== 1'b0 || state === 2'b10) begin
        errs++; $display("FAIL abort_norun k+%0d state %b rst %b want !10/0", i, state, cpu_rst_n);
      end
      if (i == 6) begin
        vec++; if (state !== 2'b00) begin errs++; $display("FAIL abort_load state %b want 00", state); end
      end
    end
  endtask

  task automatic test_write_and_run();
    do_strobe(7'h33, 8'h5C, 1'b1);
    vec++; if (state !== 2'b00) begin errs++; $display("FAIL same_cycle state %b want 00", state); end
    tick();
    vec++; if (state !== 2'b01 || mem_we !== 1'b0) begin
      errs++; $display("FAIL same_next state %b we %b want 01/0", state, mem_we);
    end
    ld_we = 1'b0;
    run_en = 1'b0;
    tick(); tick(); tick();
    vec++; if (state !== 2'b00) begin errs++; $display("FAIL same_back state %b want 00", state); end
  endtask

  task automatic test_saturate();
    int p0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_cnt = 0;
    tick();
    p0 = pulses;
    for (int unsigned n = 0; n < 260; n++) begin
      do_strobe(AW'($urandom), DW'($urandom), 1'b0);
      finish_strobe();
    end
    vec++; if (wr_count !== 8'd255) begin errs++; $display("FAIL sat_count got %0d want 255", wr_count); end
    vec++; if (pulses - p0 !== 260) begin errs++; $display("FAIL sat_pulses got %0d want 260", pulses - p0); end
  endtask

  task automatic test_reset_midwrite();
    int p0;
    ld_addr = 7'h4A; ld_data = 8'hC5;
    tick();
    p0 = pulses;
    ld_we = 1'b1;
    tick(); tick();  // k, k+1
    rst_n = 1'b0;
    exp_cnt = 0;
    #1;
    vec++; if (state !== 2'b00 || cpu_rst_n !== 1'b0 || mem_we !== 1'b0 || mem_wdata !== '0 || wr_count !== 8'd0 || cpu_gnt !== 1'b0) begin
      errs++; $display("FAIL midrst_out st %b rst %b we %b wd %h cnt %0d gnt %b want reset values",
                       state, cpu_rst_n, mem_we, mem_wdata, wr_count, cpu_gnt);
    end
    tick();  // k+2
    vec++; if (mem_we !== 1'b0) begin errs++; $display("FAIL midrst_we got %b want 0", mem_we); end
    ld_we = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      vec++; if (mem_we !== 1'b0 || wr_count !== 8'd0 || state !== 2'b00) begin
        errs++; $display("FAIL midrst_after we %b cnt %0d st %b want 0/0/00", mem_we, wr_count, state);
      end
    end
    vec++; if (pulses !== p0) begin errs++; $display("FAIL midrst_pulses got %0d want %0d", pulses, p0); end
    do_strobe(7'h06, 8'h99, 1'b0);
    finish_strobe();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_start();
    test_write_in_run();
    test_settle_abort();
    test_write_and_run();
    test_saturate();
    test_reset_midwrite();
    vec++; if (sb.size() != 0) begin errs++; $display("FAIL sb_leftover %0d writes never seen", sb.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
